// File: rtl/dm_banked_mem_if.sv
// Request/response bundle between the MEM stage and the banked data memory.
// Latency: none (wires only).
// Backpressure: req_ready from the memory stalls the master; the response side has none.
//
// Signals:
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_addr             byte address of lane 0
//   req_wstrb            per-lane write strobe; all zero means read
//   req_wdata            write data, lane i in bits [8i+7:8i]
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            read data (zero for writes)
//   rsp_err              access error flag
interface dm_banked_mem_if #(
    parameter int ADDR_W = 16,
    parameter int BYTES  = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;
    logic [BYTES-1:0]     req_wstrb;
    logic [8*BYTES-1:0]   req_wdata;
    logic                 rsp_valid;
    logic [8*BYTES-1:0]   rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_banked_mem.sv
// Byte-addressable data memory built from BYTES byte-wide banks; misaligned accesses split into two beats.
// Latency: RD_LAT cycles from accept for single-beat accesses, RD_LAT+1 for split accesses.
// Backpressure: req_ready drops for the one BEAT2 cycle of a split access; responses cannot be stalled.
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    dm_banked_mem_if slave modport (request handshake + fixed-latency response)
//
// Optional feature: define DM_ALIGN_CHECK_EN to reject any request whose address is not
// word aligned (no memory access, response carries rsp_err=1 and zero data).
module dm_banked_mem #(
    parameter int ADDR_W = 16,
    parameter int BYTES  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_banked_mem_if.slave    bus
);
    localparam int OFF_W = $clog2(BYTES);
    localparam int CW    = OFF_W + 1;
    localparam int ROW_W = ADDR_W - OFF_W;
    localparam int ROWS  = 1 << ROW_W;
    localparam int DW    = 8 * BYTES;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BEAT2 = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_rdy_en;

    // Request context held for the second beat of a split access.
    logic [ROW_W-1:0]     r_row;
    logic [OFF_W-1:0]     r_off;
    logic [BYTES-1:0]     r_wstrb;
    logic [DW-1:0]        r_wdata;
    logic                 r_is_rd;
    logic [DW-1:0]        r_hold;

    // Response pipeline; stage RD_LAT-1 drives the outputs.
    logic                 r_pv [RD_LAT];
    logic [DW-1:0]        r_pd [RD_LAT];
    logic                 r_pe [RD_LAT];

    logic                 w_req_ready;
    logic                 w_beat2;
    logic                 w_acc;
    logic                 w_beat1_go;
    logic                 w_go;
    logic                 w_reject;
    logic                 w_split;

    logic [OFF_W-1:0]     w_in_off;
    logic [ROW_W-1:0]     w_in_row;
    logic                 w_in_rd;

    // Access context of the beat executing this cycle.
    logic [OFF_W-1:0]     w_off;
    logic [ROW_W-1:0]     w_row;
    logic [BYTES-1:0]     w_wstrb;
    logic [DW-1:0]        w_wdata;

    logic [BYTES-1:0]     w_carry;
    logic [7:0]           w_rbyte [BYTES];
    logic [DW-1:0]        w_rd_lanes;

    logic                 w_s0_vld;
    logic [DW-1:0]        w_s0_dat;
    logic                 w_s0_err;

    assign w_in_off = bus.req_addr[OFF_W-1:0];
    assign w_in_row = bus.req_addr[ADDR_W-1:OFF_W];
    assign w_in_rd  = ~|bus.req_wstrb;
    assign w_acc    = bus.req_valid && w_req_ready;

`ifdef DM_ALIGN_CHECK_EN
    assign w_reject = (w_in_off != '0);
`else
    assign w_reject = 1'b0;
`endif

    // Lanes whose byte address crosses into the next row (off + i >= BYTES).
    always_comb begin
        w_carry = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_carry[i] = ({1'b0, w_off} + CW'(i)) >= CW'(BYTES);
        end
    end

    // A split is needed when beat 1 cannot cover every lane the request uses:
    // reads always use all lanes, writes only the strobed ones. Only meaningful
    // in IDLE, where w_off equals the incoming offset.
    assign w_split = (w_in_off != '0) && (w_in_rd || |(bus.req_wstrb & w_carry));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_rdy_en <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && !w_reject && w_split) w_next_state = S_BEAT2;
            S_BEAT2: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_req_ready = 1'b0;
        w_beat2     = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = r_rdy_en;
            S_BEAT2: w_beat2     = 1'b1;
            default: w_req_ready = 1'b0;
        endcase
    end

    assign w_beat1_go = w_acc && !w_reject;
    assign w_go       = w_beat1_go || w_beat2;

    assign w_off   = w_beat2 ? r_off   : w_in_off;
    assign w_row   = w_beat2 ? r_row   : w_in_row;
    assign w_wstrb = w_beat2 ? r_wstrb : bus.req_wstrb;
    assign w_wdata = w_beat2 ? r_wdata : bus.req_wdata;

    // Bank b always serves lane (b - off) mod BYTES. Beat 1 owns banks b >= off
    // on the base row; beat 2 owns banks b < off on the following row.
    for (genvar b = 0; b < BYTES; b++) begin : g_bank
        logic [7:0]       r_mem [ROWS];
        logic [OFF_W-1:0] w_lane;
        logic             w_act;
        logic             w_we;
        logic [ROW_W-1:0] w_brow;

        assign w_lane = OFF_W'(b) - w_off;
        assign w_act  = w_beat2 ? (OFF_W'(b) < w_off) : (OFF_W'(b) >= w_off);
        assign w_brow = w_beat2 ? (w_row + ROW_W'(1)) : w_row;
        assign w_we   = w_go && w_act && w_wstrb[w_lane];

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_brow] <= w_wdata[{w_lane, 3'b000} +: 8];
            end
        end

        assign w_rbyte[b] = r_mem[w_brow];
    end

    // Gather this beat's lanes back into lane order; lanes owned by the other beat read as zero.
    always_comb begin
        w_rd_lanes = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (w_carry[i] == w_beat2) begin
                w_rd_lanes[8*i +: 8] = w_rbyte[w_off + OFF_W'(i)];
            end
        end
    end

    // Capture the request on accept; r_hold keeps beat-1 read lanes for the merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row   <= '0;
            r_off   <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_is_rd <= 1'b0;
            r_hold  <= '0;
        end else if (w_acc) begin
            r_row   <= w_in_row;
            r_off   <= w_in_off;
            r_wstrb <= bus.req_wstrb;
            r_wdata <= bus.req_wdata;
            r_is_rd <= w_in_rd;
            r_hold  <= w_rd_lanes;
        end
    end

    // Response enters the pipeline on the final beat (or immediately when rejected).
    always_comb begin
        w_s0_vld = 1'b0;
        w_s0_dat = '0;
        w_s0_err = 1'b0;
        if (w_beat2) begin
            w_s0_vld = 1'b1;
            w_s0_dat = r_is_rd ? (r_hold | w_rd_lanes) : '0;
        end else if (w_acc) begin
            if (w_reject) begin
                w_s0_vld = 1'b1;
                w_s0_err = 1'b1;
            end else if (!w_split) begin
                w_s0_vld = 1'b1;
                w_s0_dat = w_in_rd ? w_rd_lanes : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pv[k] <= 1'b0;
                r_pd[k] <= '0;
                r_pe[k] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_s0_vld;
            r_pd[0] <= w_s0_dat;
            r_pe[0] <= w_s0_err;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pd[k] <= r_pd[k-1];
                r_pe[k] <= r_pe[k-1];
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_pv[RD_LAT-1];
    assign bus.rsp_rdata = r_pd[RD_LAT-1];
    assign bus.rsp_err   = r_pe[RD_LAT-1];

endmodule

// File: tb/tb_dm_banked_mem.sv
// Randomized and directed bench for dm_banked_mem against a byte-array reference model.
// Latency: each expected response carries the cycle it must appear in.
// Backpressure: requests are held until req_ready; responses are never stalled.
module tb_dm_banked_mem;
    localparam int ADDR_W = 16;
    localparam int BYTES  = 4;
    localparam int RD_LAT = 1;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_banked_mem_if #(.ADDR_W(ADDR_W), .BYTES(BYTES)) bus ();

    dm_banked_mem #(.ADDR_W(ADDR_W), .BYTES(BYTES), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mdl [0:65535];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          run_len = 0;
    int          last_rsp_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: every negedge, rsp_valid must match whether a response is due now.
    always @(negedge clk) begin
        bit due;
        if (mon_en) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("rsp_valid", bus.rsp_valid, due);
            if (bus.rsp_valid) begin
                last_rdata   = bus.rsp_rdata;
                last_err     = bus.rsp_err;
                run_len      = (last_rsp_cyc == cyc - 1) ? run_len + 1 : 1;
                last_rsp_cyc = cyc;
            end
            if (due) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_q[0].dat);
                chk("rsp_err", bus.rsp_err, exp_q[0].err);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("rsp_missed", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // Present one request at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
        int   off;
        bit   rd;
        bit   split;
        bit   rej;
        int   n;
        exp_t e;
        off   = int'(a[1:0]);
        rd    = (s == 4'h0);
        split = 1'b0;
        rej   = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (s[i] && (off + i >= BYTES)) split = 1'b1;
        end
        if (off != 0 && rd) split = 1'b1;
`ifdef DM_ALIGN_CHECK_EN
        if (off != 0) begin
            rej   = 1'b1;
            split = 1'b0;
        end
`endif
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wstrb = s;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        e.dat = '0;
        e.err = rej;
        e.cyc = cyc + RD_LAT + (split ? 1 : 0);
        if (!rej) begin
            for (int i = 0; i < BYTES; i++) begin
                if (rd) e.dat[8*i +: 8] = mdl[16'(a + i)];
                else if (s[i]) mdl[16'(a + i)] = d[8*i +: 8];
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("ready_after_acc", bus.req_ready, !split);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [3:0]  s;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1);

        // Preload the address windows used below so every read has known content.
        for (int r = 0; r < 8; r++)  do_req(16'(r * 4), 4'hF, $urandom);
        for (int r = 0; r < 16; r++) do_req(16'(16'h0100 + r * 4), 4'hF, $urandom);
        for (int r = 0; r < 8; r++)  do_req(16'(16'hFFE0 + r * 4), 4'hF, $urandom);
        drain();

        // Full write then read back
        do_req(16'h0100, 4'hF, 32'hDEADBEEF);
        do_req(16'h0100, 4'h0, 32'h0);
        drain();
        chk("t2_rd_0100", last_rdata, 32'hDEADBEEF);

        // Single-lane write
        do_req(16'h0100, 4'h2, 32'h0000AA00);
        do_req(16'h0100, 4'h0, 32'h0);
        drain();
        chk("t3_rd_0100", last_rdata, 32'hDEADAAEF);

`ifndef DM_ALIGN_CHECK_EN
        // Misaligned write split across rows
        do_req(16'h0102, 4'hF, 32'h11223344);
        do_req(16'h0100, 4'h0, 32'h0);
        drain();
        chk("t4_rd_0100", last_rdata, 32'h3344AAEF);
        do_req(16'h0104, 4'h0, 32'h0);
        drain();
        chk("t4_rd_0104_lo", last_rdata[15:0], 16'h1122);

        // Top-of-memory wrap
        do_req(16'hFFFE, 4'hF, 32'hCAFEBABE);
        do_req(16'h0000, 4'h0, 32'h0);
        drain();
        chk("t5_rd_0000_lo", last_rdata[15:0], 16'hCAFE);
        do_req(16'hFFFE, 4'h0, 32'h0);
        drain();
        chk("t5_rd_fffe", last_rdata, 32'hCAFEBABE);
`else
        // Misaligned read is rejected and leaves memory untouched
        do_req(16'h0101, 4'h0, 32'h0);
        drain();
        chk("al_err", last_err, 1);
        chk("al_rdata", last_rdata, 0);
        do_req(16'h0101, 4'hF, 32'h55555555);
        do_req(16'h0100, 4'h0, 32'h0);
        drain();
        chk("al_mem_kept", last_rdata, 32'hDEADAAEF);
`endif

        // Back-to-back aligned reads
        do_req(16'h0100, 4'h0, 32'h0);
        do_req(16'h0104, 4'h0, 32'h0);
        do_req(16'h0108, 4'h0, 32'h0);
        drain();
        chk("t6_b2b_run", run_len, 3);

        // Reset while responses are in flight
        do_req(16'h0108, 4'h0, 32'h0);
        do_req(16'h010C, 4'h0, 32'h0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_rsp_err", bus.rsp_err, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_back", bus.req_ready, 1);
        do_req(16'h0100, 4'h0, 32'h0);
        drain();

        // Randomized traffic inside the preloaded windows (one window wraps past 0xFFFF)
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) a = 16'(16'h0100 + $urandom_range(0, 60));
            else                           a = 16'(16'hFFE0 + $urandom_range(0, 60));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            do_req(a, s, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
